// File: rtl/matmul_stream_core.sv
// Streaming NxN integer matrix multiplier: loads A/B element pairs, runs one shared MAC, streams C out.
module matmul_stream_core #(
    parameter  int unsigned N  = 2,
    parameter  int unsigned W  = 4,
    localparam int unsigned CW = 2*W + $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          clear,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  a_in,
    input  logic [W-1:0]  b_in,
    input  logic          signed_mode,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] c_out,
    output logic          c_last,
    output logic          busy
);

    localparam int unsigned NN = N*N;
    localparam int unsigned IW = $clog2(NN);
    localparam int unsigned KW = $clog2(N);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [IW-1:0]  oidx_q, oidx_d;
    logic [KW-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
    logic [CW-1:0]  acc_q, acc_d;
    logic           smode_q, smode_d;
    logic           out_valid_q, out_valid_d;
    logic [CW-1:0]  c_out_q, c_out_d;
    logic           c_last_q, c_last_d;
    logic           busy_q, busy_d;

    // Operand/result storage; deliberately not reset
    logic [W-1:0]   a_mem [NN];
    logic [W-1:0]   b_mem [NN];
    logic [CW-1:0]  c_mem [NN];

    logic           ld_we_c;
    logic           c_we_c;
    logic [IW-1:0]  a_raddr_c, b_raddr_c, c_waddr_c, oidx_inc_c;
    logic [W-1:0]   a_rd_c, b_rd_c;
    logic [CW-1:0]  a_ext_c, b_ext_c, prod_c, mac_c;

    assign in_ready  = (state_q == ST_LOAD) & ena;
    assign out_valid = out_valid_q;
    assign c_out     = c_out_q;
    assign c_last    = c_last_q;
    assign busy      = busy_q;

    // MAC datapath: A[i][k] * B[k][j], extended per the latched signedness
    always_comb begin
        a_raddr_c  = IW'(i_q) * IW'(N) + IW'(k_q);
        b_raddr_c  = IW'(k_q) * IW'(N) + IW'(j_q);
        c_waddr_c  = IW'(i_q) * IW'(N) + IW'(j_q);
        oidx_inc_c = oidx_q + IW'(1);
        a_rd_c     = a_mem[a_raddr_c];
        b_rd_c     = b_mem[b_raddr_c];
        a_ext_c    = smode_q ? {{(CW-W){a_rd_c[W-1]}}, a_rd_c} : {{(CW-W){1'b0}}, a_rd_c};
        b_ext_c    = smode_q ? {{(CW-W){b_rd_c[W-1]}}, b_rd_c} : {{(CW-W){1'b0}}, b_rd_c};
        prod_c     = a_ext_c * b_ext_c;
        mac_c      = acc_q + prod_c;
    end

    // Next-state and output logic; ena=0 holds everything, clear beats normal flow
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        oidx_d      = oidx_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        acc_d       = acc_q;
        smode_d     = smode_q;
        out_valid_d = out_valid_q;
        c_out_d     = c_out_q;
        c_last_d    = c_last_q;
        busy_d      = busy_q;
        ld_we_c     = 1'b0;
        c_we_c      = 1'b0;

        if (ena) begin
            if (clear) begin
                state_d     = ST_LOAD;
                idx_d       = '0;
                oidx_d      = '0;
                i_d         = '0;
                j_d         = '0;
                k_d         = '0;
                acc_d       = '0;
                out_valid_d = 1'b0;
                c_last_d    = 1'b0;
                busy_d      = 1'b0;
            end else begin
                case (state_q)
                    ST_LOAD: begin
                        if (in_valid) begin
                            ld_we_c = 1'b1;
                            if (idx_q == '0) begin
                                smode_d = signed_mode;
                            end
                            if (idx_q == IW'(NN-1)) begin
                                idx_d   = '0;
                                state_d = ST_COMPUTE;
                                busy_d  = 1'b1;
                            end else begin
                                idx_d = idx_q + IW'(1);
                            end
                        end
                    end
                    ST_COMPUTE: begin
                        if (k_q == KW'(N-1)) begin
                            c_we_c = 1'b1;
                            acc_d  = '0;
                            k_d    = '0;
                            if (j_q == KW'(N-1)) begin
                                j_d = '0;
                                if (i_q == KW'(N-1)) begin
                                    // C[0] was completed long ago, so it can be presented now
                                    i_d         = '0;
                                    oidx_d      = '0;
                                    state_d     = ST_OUTPUT;
                                    out_valid_d = 1'b1;
                                    c_out_d     = c_mem[0];
                                    c_last_d    = 1'b0;
                                end else begin
                                    i_d = i_q + KW'(1);
                                end
                            end else begin
                                j_d = j_q + KW'(1);
                            end
                        end else begin
                            k_d   = k_q + KW'(1);
                            acc_d = mac_c;
                        end
                    end
                    ST_OUTPUT: begin
                        if (out_ready) begin
                            if (c_last_q) begin
                                state_d     = ST_LOAD;
                                out_valid_d = 1'b0;
                                c_last_d    = 1'b0;
                                busy_d      = 1'b0;
                                idx_d       = '0;
                                oidx_d      = '0;
                            end else begin
                                oidx_d   = oidx_inc_c;
                                c_out_d  = c_mem[oidx_inc_c];
                                c_last_d = (oidx_inc_c == IW'(NN-1));
                            end
                        end
                    end
                    default: begin
                        state_d = ST_LOAD;
                    end
                endcase
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_LOAD;
            idx_q       <= '0;
            oidx_q      <= '0;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            smode_q     <= 1'b0;
            out_valid_q <= 1'b0;
            c_out_q     <= '0;
            c_last_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            oidx_q      <= oidx_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            smode_q     <= smode_d;
            out_valid_q <= out_valid_d;
            c_out_q     <= c_out_d;
            c_last_q    <= c_last_d;
            busy_q      <= busy_d;
        end
    end

    // Storage write ports
    always_ff @(posedge clk) begin
        if (ld_we_c) begin
            a_mem[idx_q] <= a_in;
            b_mem[idx_q] <= b_in;
        end
        if (c_we_c) begin
            c_mem[c_waddr_c] <= mac_c;
        end
    end

endmodule

// File: tb/tb_matmul_stream_core.sv
// Self-checking bench for matmul_stream_core (N=2, W=4): spec vectors, corner sequences, random vs model.
module tb_matmul_stream_core;

    localparam int unsigned N  = 2;
    localparam int unsigned W  = 4;
    localparam int unsigned CW = 9;

    logic          clk = 1'b0;
    logic          rst_n, ena, clear, in_valid, in_ready, signed_mode;
    logic          out_valid, out_ready, c_last, busy;
    logic [W-1:0]  a_in, b_in;
    logic [CW-1:0] c_out;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        bit          sm;
        int          gap;
        int          stall_idx;
        int          stall_len;
        int          ena_at;
        int          ena_len;
        int          lat;
        logic [35:0] c;
    } vec_t;

    vec_t tbl[7];

    matmul_stream_core #(.N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
        .signed_mode(signed_mode), .out_valid(out_valid), .out_ready(out_ready),
        .c_out(c_out), .c_last(c_last), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer matrix product of the row-major element lists
    function automatic logic [35:0] model(input logic [15:0] a, input logic [15:0] b, input bit sm);
        int av[4];
        int bv[4];
        int s;
        logic [35:0] r;
        r = '0;
        for (int e = 0; e < 4; e++) begin
            av[e] = int'(a[e*4 +: 4]);
            bv[e] = int'(b[e*4 +: 4]);
            if (sm && av[e] >= 8) av[e] -= 16;
            if (sm && bv[e] >= 8) bv[e] -= 16;
        end
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                s = 0;
                for (int k = 0; k < 2; k++) s += av[i*2+k] * bv[k*2+j];
                r[(i*2+j)*9 +: 9] = 9'(s);
            end
        end
        return r;
    endfunction

    // Load four pairs; signed_mode is flipped after element 0 to prove it is latched there
    task automatic load(input logic [15:0] a, input logic [15:0] b, input bit sm, input int gap);
        for (int e = 0; e < 4; e++) begin
            if (gap > 0 && e == 1) begin
                in_valid = 1'b0;
                repeat (gap) @(posedge clk);
                #1;
            end
            in_valid    = 1'b1;
            a_in        = a[e*4 +: 4];
            b_in        = b[e*4 +: 4];
            signed_mode = (e == 0) ? sm : ~sm;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Count edges from the last load edge until out_valid, optionally dropping ena for a window
    task automatic wait_out(input string nm, input int exp_lat, input int ena_at, input int ena_len);
        int lat;
        lat = 0;
        while (!out_valid && lat < 200) begin
            if (ena_len > 0 && lat == ena_at) ena = 1'b0;
            if (lat == ena_at + ena_len) ena = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        ena = 1'b1;
        check({nm, ".latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic drain(input string nm, input logic [35:0] c, input int stall_idx, input int stall_len);
        for (int e = 0; e < 4; e++) begin
            logic [8:0] ev;
            ev = c[e*9 +: 9];
            if (e == stall_idx) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    @(posedge clk);
                    #1;
                    check({nm, ".hold_data"}, 32'(c_out), 32'(ev));
                    check({nm, ".hold_valid"}, 32'(out_valid), 32'd1);
                end
            end
            out_ready = 1'b1;
            check({nm, ".c_out"}, 32'(c_out), 32'(ev));
            check({nm, ".out_valid"}, 32'(out_valid), 32'd1);
            check({nm, ".c_last"}, 32'(c_last), 32'(e == 3));
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
        check({nm, ".done_valid"}, 32'(out_valid), 32'd0);
        check({nm, ".done_busy"}, 32'(busy), 32'd0);
        check({nm, ".done_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run(input string nm, input vec_t v);
        load(v.a, v.b, v.sm, v.gap);
        check({nm, ".busy"}, 32'(busy), 32'd1);
        check({nm, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        wait_out(nm, v.lat, v.ena_at, v.ena_len);
        drain(nm, v.c, v.stall_idx, v.stall_len);
    endtask

    initial begin
        vec_t v;
        bit   seen;

        tbl[0] = '{16'h4321, 16'h8765, 1'b0, 0, -1, 0, 0, 0,  8, {9'd50, 9'd43, 9'd22, 9'd19}};
        tbl[1] = '{16'hC32F, 16'h8765, 1'b1, 0, -1, 0, 0, 0,  8, {9'h032, 9'h1F3, 9'h1EA, 9'h009}};
        tbl[2] = '{16'h8888, 16'h8888, 1'b1, 0, -1, 0, 0, 0,  8, {4{9'h080}}};
        tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 0, -1, 0, 0, 0,  8, {4{9'h1C2}}};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 0, -1, 0, 0, 0,  8, {4{9'h002}}};
        tbl[5] = '{16'h4321, 16'h8765, 1'b0, 0,  1, 3, 0, 0,  8, {9'd50, 9'd43, 9'd22, 9'd19}};
        tbl[6] = '{16'h4321, 16'h8765, 1'b0, 2, -1, 0, 3, 5, 13, {9'd50, 9'd43, 9'd22, 9'd19}};

        rst_n = 1'b0; ena = 1'b1; clear = 1'b0; in_valid = 1'b0;
        a_in = '0; b_in = '0; signed_mode = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.c_last", 32'(c_last), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.c_out", 32'(c_out), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst.in_ready", 32'(in_ready), 32'd1);

        // ena=0 in LOAD: not ready, and a presented element must not be taken
        ena = 1'b0;
        #1;
        check("ena0.in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1; a_in = 4'hF; b_in = 4'hF;
        @(posedge clk);
        #1;
        in_valid = 1'b0; ena = 1'b1;

        // clear together with in_valid: element dropped
        in_valid = 1'b1; clear = 1'b1; a_in = 4'hE; b_in = 4'hE;
        @(posedge clk);
        #1;
        in_valid = 1'b0; clear = 1'b0;

        for (int t = 0; t < 7; t++) run($sformatf("tbl%0d", t), tbl[t]);

        // clear on the 4th compute edge aborts; output must never appear
        load(16'h4321, 16'h8765, 1'b0, 0);
        repeat (3) begin @(posedge clk); #1; end
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check("clr.in_ready", 32'(in_ready), 32'd1);
        check("clr.busy", 32'(busy), 32'd0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("clr.no_output", 32'(seen), 32'd0);
        run("clr.reload", tbl[1]);

        // async reset in the middle of the last output element
        load(16'h4321, 16'h8765, 1'b0, 0);
        wait_out("rstmid", 8, 0, 0);
        out_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        out_ready = 1'b0;
        check("rstmid.c_last_before", 32'(c_last), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid.out_valid", 32'(out_valid), 32'd0);
        check("rstmid.c_last", 32'(c_last), 32'd0);
        check("rstmid.busy", 32'(busy), 32'd0);
        check("rstmid.c_out", 32'(c_out), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rstmid.in_ready", 32'(in_ready), 32'd1);
        run("rstmid.reload", tbl[0]);

        // random operands against the reference model
        for (int r = 0; r < 40; r++) begin
            v.a         = 16'($urandom);
            v.b         = 16'($urandom);
            v.sm        = 1'($urandom_range(0, 1));
            v.gap       = int'($urandom_range(0, 2));
            v.stall_idx = int'($urandom_range(0, 5)) - 1;
            v.stall_len = int'($urandom_range(1, 3));
            v.ena_at    = 0;
            v.ena_len   = 0;
            v.lat       = 8;
            v.c         = model(v.a, v.b, v.sm);
            run($sformatf("rnd%0d", r), v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
